bcd_display_scanner: RTL and testbench
======================================

// Module: bcd_display_scanner
// PURPOSE
//  Downstream stage of the N-bit sequential multiplier. Captures the packed BCD product
//  when the multiplier's finish rises and holds it. Time-multiplexes the digits onto a
//  common-anode 7-segment display, with leading-zero blanking and an inter-digit ghost guard.
// PARAMETERS
//  N_BITS    5                   multiplier operand width; sets the product digit count
//  DIGITS    ((2*N_BITS)/3)+1    BCD digits in bcd (4 at default)
//  PRESCALE  4                   clk cycles per digit slot; must be >=2 (board: 50000)
// PORTS
//  clk     in   1          system clock, rising edge
//  reset   in   1          asynchronous, active-low; clears all state
//  bcd     in   DIGITS*4   packed BCD product from multiplier, digit0 = bcd[3:0] (LSD)
//  finish  in   1          multiplier done level; capture on its rising edge only
//  an      out  DIGITS     digit enables, active-low, one-hot-low or all-high
//  seg     out  7          segments {g,f,e,d,c,b,a}, active-low
//  valid   out  1          high once a product has been captured
// BEHAVIOUR
//  - Reset (reset=0, async): hold=0, valid=0, finish_d=0, pcnt=0, idx=0,
//    an=all 1, seg=7'h7F. All outputs are registered.
//  - Capture: cap = finish & ~finish_d, with finish_d = finish delayed one clk.
//    - On cap at edge k: hold<=bcd and valid<=1 at edge k. Display reflects the new hold from edge k+1.
//    - finish held high captures once. A new capture needs finish to go low, then high.
//  - Prescaler: pcnt counts 0..PRESCALE-1, then wraps to 0.
//    - At pcnt==PRESCALE-1, idx advances by 1. It wraps from DIGITS-1 to 0.
//    - The scan runs continuously from reset, whether or not valid is set.
//  - Output register, evaluated each clk from the pre-edge idx/pcnt/hold/valid:
//    - If valid=0, or pcnt==0 (ghost guard), or digit idx is blanked: an=all 1, seg=7'h7F.
//    - Otherwise: an=~(1<<idx), seg=decode(hold[idx*4+:4]).
//  - Leading-zero blanking: digit i>0 is blanked when digits i..DIGITS-1 are all 0.
//    Digit 0 is never blanked, so a product of 0 shows a single "0".
//  - decode table, active-low gfedcba:
//    0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 (hex).
//    Nibbles A-F show "-" = 7'h3F and count as non-zero for blanking.
//  - Simultaneous cap and idx advance: both take effect. The next output cycle uses the new idx with the old
//    hold (pre-edge values); the new hold appears one cycle later.
//  - Reset asserted mid-scan: immediate blank, and the counters return to 0.
//    After release, the scan restarts at idx=0, pcnt=0.
//  - Widths: pcnt is $clog2(PRESCALE) bits and idx is $clog2(DIGITS) bits (min 1).
//    idx never reaches DIGITS.
// STRUCTURE
//  - Shared package:
//    - SEG_* active-low segment constants (digits 0-9, DASH, BLANK).
//    - DIGITS_OF(n) constant function.
//  - One sub-module, seg7_decode: combinational 4-bit nibble -> 7-bit active-low seg, per the table above.
//  - Top level: edge detect, hold register, prescaler, idx counter, blank logic, output register.
// TESTING (PRESCALE=4, DIGITS=4)
//  1. Reset low for 2 clk, then release, with finish=0 -> an=4'hF, seg=7'h7F, valid=0 for
//     >=2 full scans.
//  2. bcd=16'h0780 (26*30), finish rises ->
//     - valid=1.
//     - Per scan: digit0 seg=40, digit1 seg=00, digit2 seg=78; digit3 never enabled.
//     - Each enabled slot lasts 3 clk; an=F in the pcnt==0 cycle.
//  3. finish stays high, bcd changes to 16'h0169 -> display unchanged.
//     Drop finish, raise it again -> digits show 10, 02, 79; digit3 blanked.
//  4. bcd=16'h0000 captured -> only an=4'hE active (seg=40); an=4'hD/B/7 never seen.
//  5. bcd=16'h0A05 captured -> digit0=12, digit1=40 (not blanked), digit2=3F, digit3 blanked.
//  6. Pull reset low mid-slot on digit2 -> same-cycle an=F, seg=7F, valid=0.
//     After release, the first enabled digit is idx0 only after a new capture.

Source files
------------

// File: rtl/bcd_display_scanner_pkg.sv
// bcd_display_scanner_pkg: shared segment constants and digit-count helper for the BCD display scanner
package bcd_display_scanner_pkg;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Number of BCD digits needed for the product of two n-bit operands
    function automatic int DIGITS_OF(input int n);
        return ((2 * n) / 3) + 1;
    endfunction

endpackage

// File: rtl/bcd_display_scanner_seg7_decode.sv
// seg7_decode: BCD nibble to active-low {g,f,e,d,c,b,a}; non-decimal nibbles show a dash
module seg7_decode
    import bcd_display_scanner_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    // Pure lookup; A-F fall through to the dash pattern
    always_comb begin
        case (nib)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd_display_scanner.sv
// bcd_display_scanner: captures the BCD product on finish rise and scans it onto a multiplexed 7-segment display
module bcd_display_scanner
    import bcd_display_scanner_pkg::*;
#(
    parameter int N_BITS   = 5,
    parameter int DIGITS   = DIGITS_OF(N_BITS),
    parameter int PRESCALE = 4
)(
    input  logic                clk,
    input  logic                reset,
    input  logic [DIGITS*4-1:0] bcd,
    input  logic                finish,
    output logic [DIGITS-1:0]   an,
    output logic [6:0]          seg,
    output logic                valid
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(PRESCALE - 1);
    localparam logic [IW-1:0] I_LAST = IW'(DIGITS - 1);

    logic [DIGITS*4-1:0] hold_q, hold_d;
    logic                valid_q, valid_d;
    logic                finish_q, finish_d;
    logic [PW-1:0]       pcnt_q, pcnt_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [DIGITS-1:0]   an_q, an_d;
    logic [6:0]          seg_q, seg_d;
    logic [DIGITS-1:0]   blank;
    logic [3:0]          nib;
    logic [6:0]          dec_seg;
    logic                cap;
    logic                show;

    assign cap = finish & ~finish_q;
    assign nib = hold_q[{idx_q, 2'b00} +: 4];

    seg7_decode u_dec (
        .nib (nib),
        .seg (dec_seg)
    );

    // Digit i>0 is blank when it and every more-significant digit are zero
    always_comb begin
        blank = '0;
        for (int i = 1; i < DIGITS; i++)
            blank[i] = (hold_q >> (4 * i)) == '0;
    end

    // Next-state: capture, prescaler, digit index, and the ghost-guarded output
    always_comb begin
        finish_d = finish;
        hold_d   = cap ? bcd : hold_q;
        valid_d  = valid_q | cap;
        pcnt_d   = (pcnt_q == P_LAST) ? '0 : pcnt_q + 1'b1;
        idx_d    = (pcnt_q != P_LAST) ? idx_q : (idx_q == I_LAST) ? '0 : idx_q + 1'b1;
        show     = valid_q && (pcnt_q != '0) && !blank[idx_q];
        an_d     = show ? ~(DIGITS'(1) << idx_q) : '1;
        seg_d    = show ? dec_seg : SEG_BLANK;
    end

    // State and registered outputs, cleared asynchronously
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_q   <= '0;
            valid_q  <= 1'b0;
            finish_q <= 1'b0;
            pcnt_q   <= '0;
            idx_q    <= '0;
            an_q     <= '1;
            seg_q    <= SEG_BLANK;
        end else begin
            hold_q   <= hold_d;
            valid_q  <= valid_d;
            finish_q <= finish_d;
            pcnt_q   <= pcnt_d;
            idx_q    <= idx_d;
            an_q     <= an_d;
            seg_q    <= seg_d;
        end
    end

    assign an    = an_q;
    assign seg   = seg_q;
    assign valid = valid_q;

endmodule

// File: tb/tb_bcd_display_scanner.sv
// tb_bcd_display_scanner: directed table-driven check of capture, scanning, blanking and reset behaviour
module tb_bcd_display_scanner;

    logic        clk    = 1'b0;
    logic        reset  = 1'b1;
    logic        finish = 1'b0;
    logic [15:0] bcd    = '0;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        valid;

    int n_cmp = 0;
    int n_bad = 0;

    bcd_display_scanner #(.N_BITS(5), .PRESCALE(4)) dut (
        .clk    (clk),
        .reset  (reset),
        .bcd    (bcd),
        .finish (finish),
        .an     (an),
        .seg    (seg),
        .valid  (valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0]     bcd;
        bit              pulse;
        logic [3:0][6:0] segs;
        logic [3:0]      en;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic observe(input logic [3:0][6:0] es, input logic [3:0] en_exp, input string tag);
        int cnt[4];
        int bad_seg = 0;
        int bad_an = 0;
        int bad_blank = 0;
        int ghost = 0;
        logic [3:0] oh;
        bit found;
        for (int d = 0; d < 4; d++) cnt[d] = 0;
        repeat (32) begin
            @(negedge clk);
            if (an == 4'hF) begin
                ghost++;
                if (seg !== 7'h7F) bad_blank++;
            end else begin
                found = 1'b0;
                for (int d = 0; d < 4; d++) begin
                    oh = 4'b0001 << d;
                    if (an == ~oh) begin
                        found = 1'b1;
                        cnt[d]++;
                        if (seg !== es[d]) bad_seg++;
                    end
                end
                if (!found) bad_an++;
            end
        end
        for (int d = 0; d < 4; d++)
            chk($sformatf("%s digit%0d enabled cycles", tag, d), cnt[d], en_exp[d] ? 6 : 0);
        chk({tag, " wrong seg"}, bad_seg, 0);
        chk({tag, " illegal an"}, bad_an, 0);
        chk({tag, " blank seg"}, bad_blank, 0);
        chk({tag, " blank cycles"}, ghost, 32 - 6 * $countones(en_exp));
    endtask

    logic [3:0] seq_an[15]  = '{4'hF, 4'hE, 4'hE, 4'hE, 4'hF, 4'hD, 4'hD, 4'hD,
                                4'hF, 4'hB, 4'hB, 4'hB, 4'hF, 4'h7, 4'h7};
    logic [6:0] seq_seg[15] = '{7'h7F, 7'h19, 7'h19, 7'h19, 7'h7F, 7'h30, 7'h30, 7'h30,
                                7'h7F, 7'h24, 7'h24, 7'h24, 7'h7F, 7'h12, 7'h12};

    initial begin
        int bad;
        bit got;
        vecs[0] = '{16'h0780, 1'b1, {7'h7F, 7'h78, 7'h00, 7'h40}, 4'b0111};
        vecs[1] = '{16'h0169, 1'b0, {7'h7F, 7'h78, 7'h00, 7'h40}, 4'b0111};
        vecs[2] = '{16'h0169, 1'b1, {7'h7F, 7'h79, 7'h02, 7'h10}, 4'b0111};
        vecs[3] = '{16'h0000, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b0001};
        vecs[4] = '{16'h9999, 1'b1, {7'h10, 7'h10, 7'h10, 7'h10}, 4'b1111};
        vecs[5] = '{16'h1000, 1'b1, {7'h79, 7'h40, 7'h40, 7'h40}, 4'b1111};
        vecs[6] = '{16'h00F0, 1'b1, {7'h7F, 7'h7F, 7'h3F, 7'h40}, 4'b0011};
        vecs[7] = '{16'h2345, 1'b1, {7'h24, 7'h30, 7'h19, 7'h12}, 4'b1111};
        vecs[8] = '{16'h0087, 1'b1, {7'h7F, 7'h7F, 7'h00, 7'h78}, 4'b0011};
        vecs[9] = '{16'h0A05, 1'b1, {7'h7F, 7'h3F, 7'h40, 7'h12}, 4'b0111};

        #1 reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset an", an, 4'hF);
        chk("reset seg", seg, 7'h7F);
        chk("reset valid", valid, 1'b0);
        reset = 1'b1;
        bad = 0;
        repeat (32) begin
            @(negedge clk);
            if (an !== 4'hF || seg !== 7'h7F || valid !== 1'b0) bad++;
        end
        chk("idle before capture", bad, 0);

        for (int v = 0; v < 10; v++) begin
            if (vecs[v].pulse) begin
                finish = 1'b0;
                @(negedge clk);
                bcd = vecs[v].bcd;
                finish = 1'b1;
            end else begin
                bcd = vecs[v].bcd;
            end
            repeat (3) @(negedge clk);
            chk($sformatf("vec%0d valid", v), valid, 1'b1);
            observe(vecs[v].segs, vecs[v].en, $sformatf("vec%0d", v));
        end

        got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            if (an == 4'hB) got = 1'b1;
        end
        chk("digit2 slot reached", got, 1'b1);
        chk("digit2 seg before reset", seg, 7'h3F);
        reset = 1'b0;
        #1;
        chk("mid-slot reset an", an, 4'hF);
        chk("mid-slot reset seg", seg, 7'h7F);
        chk("mid-slot reset valid", valid, 1'b0);
        @(negedge clk);
        bcd = 16'h1234;
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            chk($sformatf("restart cycle%0d an", k + 1), an, seq_an[k]);
            chk($sformatf("restart cycle%0d seg", k + 1), seg, seq_seg[k]);
            if (k == 1) chk("restart valid", valid, 1'b1);
            if (k == 9) finish = 1'b0;
            if (k == 10) begin
                finish = 1'b1;
                bcd = 16'h5678;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
